// File: rtl/mc_controller.sv
// mc_controller -- main control FSM of the multicycle RV32I core.
//
// Sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WB steps and
// drives the datapath mux selects, write enables and ALUControl. One memory
// port is shared between instruction fetch and load/store; every access is a
// req/ready handshake, so a slow memory can stretch FETCH, MEMREAD and
// MEMWRITE by any number of wait cycles.
//
// Ports
//   clk, reset            core clock, synchronous active-high reset
//   op/funct3/funct7b5    instruction fields from the datapath IR
//   Zero/LessS/LessU      ALU flags used to resolve branches
//   mem_ready             memory completes the requested access this cycle
//   mem_req, MemWrite     memory request and store strobe
//   AdrSrc                memory address: 0 = PC, 1 = Result
//   IRWrite, PCWrite      load IR/OldPC, load PC from Result
//   RegWrite              register file write
//   ALUSrcA/ALUSrcB       ALU operand selects
//   ResultSrc             Result mux select
//   ImmSrc                immediate format, decoded from op in every state
//   ALUControl            ALU operation
//   instr_done            one-cycle pulse on the last cycle of an instruction
//   halted                illegal instruction trapped; only reset leaves it
module mc_controller #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       LessS,
  input  logic       LessU,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [2:0] ImmSrc,
  output logic [3:0] ALUControl,
  output logic       instr_done,
  output logic       halted
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LUI      = 4'd12,
    S_HALT     = 4'd13
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SLT   = 4'b0101;
  localparam logic [3:0] ALU_SLTU  = 4'b0110;
  localparam logic [3:0] ALU_SLL   = 4'b0111;
  localparam logic [3:0] ALU_SRL   = 4'b1000;
  localparam logic [3:0] ALU_SRA   = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1010;

  state_t     state_q, state_d;
  logic [3:0] alu_dec;
  logic       br_legal, br_taken;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its input from before the edge, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset) state_q <= state_t'(RESET_STATE);
    else       state_q <= state_d;
  end

  // Immediate format follows op in every state, so the extender is ready
  // as soon as IR loads.
  always_comb begin
    case (op)
      OP_STORE:          ImmSrc = 3'b001;
      OP_BRANCH:         ImmSrc = 3'b010;
      OP_JAL:            ImmSrc = 3'b011;
      OP_LUI, OP_AUIPC:  ImmSrc = 3'b100;
      default:           ImmSrc = 3'b000;
    endcase
  end

  // ALU operation for register/immediate arithmetic. funct7b5 selects sub
  // only for R-type (for addi it is just an immediate bit); for shifts it
  // selects arithmetic right shift in both forms.
  always_comb begin
    case (funct3)
      3'b000:  alu_dec = (op == OP_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_dec = ALU_SLL;
      3'b010:  alu_dec = ALU_SLT;
      3'b011:  alu_dec = ALU_SLTU;
      3'b100:  alu_dec = ALU_XOR;
      3'b101:  alu_dec = funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_dec = ALU_OR;
      default: alu_dec = ALU_AND;
    endcase
  end

  // Branch resolution from the flags of the sub in the BRANCH step.
  always_comb begin
    br_legal = 1'b1;
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = Zero;
      3'b001:  br_taken = !Zero;
      3'b100:  br_taken = LessS;
      3'b101:  br_taken = !LessS;
      3'b110:  br_taken = LessU;
      3'b111:  br_taken = !LessU;
      default: br_legal = 1'b0;
    endcase
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave a latch behind.
    state_d    = state_q;
    mem_req    = 1'b0;
    MemWrite   = 1'b0;
    AdrSrc     = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = ALU_ADD;
    instr_done = 1'b0;
    halted     = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTER;
          OP_ITYPE:          state_d = S_EXECUTEI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_ALUWB;
          default:           state_d = S_HALT;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        // op[5] is the only bit separating store from load.
        state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_EXECUTER: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_dec;
        state_d    = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_dec;
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = ALU_SUB;
        if (br_legal) begin
          PCWrite    = br_taken;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end else begin
          state_d = S_HALT;
        end
      end
      S_JAL: begin
        // ALUOut already holds the target; the ALU forms the link OldPC+4.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
        state_d = S_ALUWB;
      end
      S_JALR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = S_JAL;
      end
      S_LUI: begin
        ALUSrcB    = 2'b01;
        ALUControl = ALU_PASSB;
        state_d    = S_ALUWB;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset squashes every side effect in the same cycle, even mid-access.
    if (reset) begin
      mem_req    = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      RegWrite   = 1'b0;
      instr_done = 1'b0;
      halted     = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller -- self-checking bench for mc_controller.
//
// The reference model describes each instruction as an ordered list of
// phases built from its opcode; a compare process walks that list one phase
// per cycle (memory phases hold while mem_ready is low) and checks every DUT
// output against what the phase must drive. Directed runs additionally pin
// hand-computed totals: cycle count, instr_done pulses, RegWrite, PCWrite,
// MemWrite and load-address cycles per instruction.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, Zero, LessS, LessU, mem_ready;
  logic       mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic [2:0] ImmSrc;
  logic [3:0] ALUControl;
  logic       instr_done, halted;

  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .LessS(LessS), .LessU(LessU), .mem_ready(mem_ready),
    .mem_req(mem_req), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .instr_done(instr_done), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] src_a, src_b, res_src;
    logic [2:0] imm_src;
    logic [3:0] alu;
    logic done, halt;
  } outs_t;

  typedef enum {
    PH_FETCH, PH_DECODE, PH_EA, PH_RD, PH_RDWB, PH_WR, PH_OP_R, PH_OP_I,
    PH_WB, PH_BR, PH_LINK, PH_JTGT, PH_LUI, PH_STOP
  } phase_t;

  int     n_checks = 0, n_fail = 0;
  int     n_done = 0, n_regw = 0, n_pcw = 0, n_memw = 0, n_rd = 0;
  phase_t m_plan[$];
  int     m_idx = 0;
  logic   m_fresh = 1'b1;
  outs_t  m_e, m_c;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [2:0] imm_of(input logic [6:0] o);
    case (o)
      7'b0100011:             return 3'b001;
      7'b1100011:             return 3'b010;
      7'b1101111:             return 3'b011;
      7'b0110111, 7'b0010111: return 3'b100;
      default:                return 3'b000;
    endcase
  endfunction

  function automatic logic [3:0] alu_of(input logic r_type);
    case (funct3)
      3'd0: return (r_type && funct7b5) ? 4'd1 : 4'd0;
      3'd1: return 4'd7;
      3'd2: return 4'd5;
      3'd3: return 4'd6;
      3'd4: return 4'd4;
      3'd5: return funct7b5 ? 4'd9 : 4'd8;
      3'd6: return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  function automatic void build_plan();
    m_plan.delete();
    m_plan.push_back(PH_FETCH);
    m_plan.push_back(PH_DECODE);
    case (op)
      7'b0000011: begin m_plan.push_back(PH_EA); m_plan.push_back(PH_RD); m_plan.push_back(PH_RDWB); end
      7'b0100011: begin m_plan.push_back(PH_EA); m_plan.push_back(PH_WR); end
      7'b0110011: begin m_plan.push_back(PH_OP_R); m_plan.push_back(PH_WB); end
      7'b0010011: begin m_plan.push_back(PH_OP_I); m_plan.push_back(PH_WB); end
      7'b1100011: begin
        m_plan.push_back(PH_BR);
        if (funct3[2:1] == 2'b01) m_plan.push_back(PH_STOP);
      end
      7'b1101111: begin m_plan.push_back(PH_LINK); m_plan.push_back(PH_WB); end
      7'b1100111: begin m_plan.push_back(PH_JTGT); m_plan.push_back(PH_LINK); m_plan.push_back(PH_WB); end
      7'b0110111: begin m_plan.push_back(PH_LUI); m_plan.push_back(PH_WB); end
      7'b0010111: m_plan.push_back(PH_WB);
      default:    m_plan.push_back(PH_STOP);
    endcase
  endfunction

  function automatic void base_expect();
    m_e = '0;
    m_c = '0;
    {m_c.mem_req, m_c.mem_write, m_c.ir_write, m_c.pc_write, m_c.reg_write} = 5'b11111;
    m_c.imm_src = 3'b111;
    m_c.done    = 1'b1;
    m_c.halt    = 1'b1;
    m_e.imm_src = imm_of(op);
  endfunction

  function automatic void want(input logic [1:0] a, input logic [1:0] b, input logic [3:0] alu);
    m_e.src_a = a;   m_c.src_a = 2'b11;
    m_e.src_b = b;   m_c.src_b = 2'b11;
    m_e.alu   = alu; m_c.alu   = 4'hF;
  endfunction

  function automatic void want_res(input logic [1:0] r);
    m_e.res_src = r; m_c.res_src = 2'b11;
  endfunction

  function automatic void want_adr(input logic v);
    m_e.adr_src = v; m_c.adr_src = 1'b1;
  endfunction

  function automatic void model_out(input phase_t p, input logic fin);
    logic taken;
    base_expect();
    m_e.done = fin;
    case (p)
      PH_FETCH: begin
        m_e.mem_req = 1'b1; m_e.ir_write = mem_ready; m_e.pc_write = mem_ready;
        want_adr(1'b0); want(2'b00, 2'b10, 4'd0); want_res(2'b10);
      end
      PH_DECODE: want(2'b01, 2'b01, 4'd0);
      PH_EA:     want(2'b10, 2'b01, 4'd0);
      PH_RD:     begin m_e.mem_req = 1'b1; want_adr(1'b1); want_res(2'b00); end
      PH_RDWB:   begin m_e.reg_write = 1'b1; want_res(2'b01); end
      PH_WR:     begin m_e.mem_req = 1'b1; m_e.mem_write = 1'b1; want_adr(1'b1); want_res(2'b00); end
      PH_OP_R:   want(2'b10, 2'b00, alu_of(1'b1));
      PH_OP_I:   want(2'b10, 2'b01, alu_of(1'b0));
      PH_WB:     begin m_e.reg_write = 1'b1; want_res(2'b00); end
      PH_BR: begin
        taken = (funct3[2] ? (funct3[1] ? LessU : LessS) : Zero) ^ funct3[0];
        m_e.pc_write = taken && (funct3[2:1] != 2'b01);
        want(2'b10, 2'b00, 4'd1); want_res(2'b00);
      end
      PH_LINK:   begin m_e.pc_write = 1'b1; want(2'b01, 2'b10, 4'd0); want_res(2'b00); end
      PH_JTGT:   want(2'b10, 2'b01, 4'd0);
      PH_LUI:    begin m_e.src_b = 2'b01; m_c.src_b = 2'b11; m_e.alu = 4'd10; m_c.alu = 4'hF; end
      default:   m_e.halt = 1'b1;
    endcase
  endfunction

  // ---------------- per-cycle compare ----------------
  initial begin : compare
    outs_t  a;
    phase_t p;
    logic   stall, adv, fin;
    forever begin
      @(negedge clk);
      a = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ALUSrcA, ALUSrcB,
           ResultSrc, ImmSrc, ALUControl, instr_done, halted};
      if (reset) begin
        base_expect();
        check("reset_outputs", a & m_c, m_e & m_c);
        m_fresh = 1'b1;
      end else begin
        if (m_fresh) begin
          build_plan();
          m_idx   = 0;
          m_fresh = 1'b0;
        end
        p     = m_plan[m_idx];
        stall = (p == PH_FETCH || p == PH_RD || p == PH_WR) && !mem_ready;
        adv   = (p != PH_STOP) && !stall;
        fin   = adv && (m_idx == m_plan.size() - 1);
        model_out(p, fin);
        check({"cycle_", p.name()}, a & m_c, m_e & m_c);
        if (instr_done === 1'b1)                    n_done++;
        if (RegWrite === 1'b1)                      n_regw++;
        if (PCWrite === 1'b1)                       n_pcw++;
        if (MemWrite === 1'b1)                      n_memw++;
        if ((mem_req && AdrSrc && !MemWrite) === 1'b1) n_rd++;
        if (adv) begin
          if (fin) m_fresh = 1'b1;
          else     m_idx++;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  // Runs one instruction for ncyc cycles with mem_ready low for low_n cycles
  // starting at cycle low_from, then checks hand-computed totals.
  task automatic run(input string name, input logic [6:0] o, input logic [2:0] f3,
                     input logic f7, input logic [2:0] zsu, input int low_from,
                     input int low_n, input int ncyc, input int e_done, input int e_regw,
                     input int e_pcw, input int e_memw, input int e_rd);
    int b_done, b_regw, b_pcw, b_memw, b_rd;
    op = o; funct3 = f3; funct7b5 = f7;
    {Zero, LessS, LessU} = zsu;
    b_done = n_done; b_regw = n_regw; b_pcw = n_pcw; b_memw = n_memw; b_rd = n_rd;
    for (int c = 0; c < ncyc; c++) begin
      mem_ready = !(c >= low_from && c < low_from + low_n);
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b1;
    check({name, "_done"},  n_done - b_done, e_done);
    check({name, "_regw"},  n_regw - b_regw, e_regw);
    check({name, "_pcw"},   n_pcw - b_pcw,   e_pcw);
    check({name, "_memw"},  n_memw - b_memw, e_memw);
    check({name, "_rdadr"}, n_rd - b_rd,     e_rd);
    check({name, "_model_len"}, m_fresh, e_done != 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    reset = 1'b1; mem_ready = 1'b1; op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0;
    Zero = 1'b0; LessS = 1'b0; LessU = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    //   name        op          f3      f7    {Z,LS,LU} lf ln cyc done regw pcw memw rd
    run("add",    7'b0110011, 3'b000, 1'b0, 3'b000, 0, 0, 4, 1, 1, 1, 0, 0);
    run("sub",    7'b0110011, 3'b000, 1'b1, 3'b000, 0, 0, 4, 1, 1, 1, 0, 0);
    run("addi30", 7'b0010011, 3'b000, 1'b1, 3'b000, 0, 0, 4, 1, 1, 1, 0, 0);
    run("srai",   7'b0010011, 3'b101, 1'b1, 3'b000, 0, 0, 4, 1, 1, 1, 0, 0);
    run("sltu",   7'b0110011, 3'b011, 1'b0, 3'b000, 0, 0, 4, 1, 1, 1, 0, 0);
    run("srl",    7'b0110011, 3'b101, 1'b0, 3'b000, 0, 0, 4, 1, 1, 1, 0, 0);
    run("xori",   7'b0010011, 3'b100, 1'b0, 3'b000, 0, 0, 4, 1, 1, 1, 0, 0);
    run("lw_wait",7'b0000011, 3'b010, 1'b0, 3'b000, 3, 3, 8, 1, 1, 1, 0, 4);
    run("lw",     7'b0000011, 3'b010, 1'b0, 3'b000, 0, 0, 5, 1, 1, 1, 0, 1);
    run("sw_wait",7'b0100011, 3'b010, 1'b0, 3'b000, 3, 2, 6, 1, 0, 1, 3, 0);
    run("sw",     7'b0100011, 3'b010, 1'b0, 3'b000, 0, 0, 4, 1, 0, 1, 1, 0);
    run("bne_z",  7'b1100011, 3'b001, 1'b0, 3'b100, 0, 0, 3, 1, 0, 1, 0, 0);
    run("bltu_t", 7'b1100011, 3'b110, 1'b0, 3'b001, 0, 0, 3, 1, 0, 2, 0, 0);
    run("bge_lt", 7'b1100011, 3'b101, 1'b0, 3'b010, 0, 0, 3, 1, 0, 1, 0, 0);
    run("beq_t",  7'b1100011, 3'b000, 1'b0, 3'b100, 0, 0, 3, 1, 0, 2, 0, 0);
    run("jal",    7'b1101111, 3'b000, 1'b0, 3'b000, 0, 0, 4, 1, 1, 2, 0, 0);
    run("jalr",   7'b1100111, 3'b000, 1'b0, 3'b000, 0, 0, 5, 1, 1, 2, 0, 0);
    run("lui",    7'b0110111, 3'b000, 1'b0, 3'b000, 0, 0, 4, 1, 1, 1, 0, 0);
    run("auipc",  7'b0010111, 3'b000, 1'b0, 3'b000, 0, 0, 3, 1, 1, 1, 0, 0);
    run("ifetch_wait", 7'b0110011, 3'b111, 1'b0, 3'b000, 0, 2, 6, 1, 1, 1, 0, 0);

    // Illegal opcode: FETCH, DECODE, then 10 cycles parked in HALT.
    run("halt",   7'b0000000, 3'b000, 1'b0, 3'b000, 0, 0, 12, 0, 0, 1, 0, 0);
    check("halted_flag", halted, 1'b1);

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Store stalled in MEMWRITE, then reset lands during the wait.
    run("sw_abort", 7'b0100011, 3'b010, 1'b0, 3'b000, 3, 10, 5, 0, 0, 1, 2, 0);
    mem_ready = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    check("abort_memwrite", MemWrite, 1'b0);
    check("abort_memreq",   mem_req,  1'b0);
    @(posedge clk);
    #1 reset = 1'b0; mem_ready = 1'b1;
    run("after_abort", 7'b0110011, 3'b000, 1'b0, 3'b000, 0, 0, 4, 1, 1, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
